// File: rtl/gpu_pkg.sv
// gpu_pkg: shared widths, pixel/address types and frame-buffer region sizing
package gpu_pkg;

    localparam int DEF_COLOR_WIDTH   = 16;
    localparam int DEF_BUFFER_ADDR_W = 32;

    typedef logic [DEF_COLOR_WIDTH-1:0]   color_t;
    typedef logic [DEF_BUFFER_ADDR_W-1:0] buf_addr_t;

    function automatic int region_words(int x_size, int y_size, int cores);
        return x_size * y_size / cores;
    endfunction

endpackage

// File: rtl/ppu_wr_fifo.sv
// ppu_wr_fifo: per-core FIFO of {colour, word offset} with first-word-fall-through head
module ppu_wr_fifo #(
    parameter int DW    = 16,
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] color_i,
    input  logic [AW-1:0] offs_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] color_o,
    output logic [AW-1:0] offs_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]   wr_q, rd_q;
    logic [DW-1:0] color_q [DEPTH];
    logic [AW-1:0] offs_q  [DEPTH];

    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign color_o = color_q[rd_q[PW-1:0]];
    assign offs_o  = offs_q[rd_q[PW-1:0]];

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (PW+1)'(push_i);
            rd_q <= rd_q + (PW+1)'(pop_i);
        end
    end

    // Storage; a push into a full FIFO only happens alongside a pop of the same slot
    always_ff @(posedge clk) begin
        if (push_i) begin
            color_q[wr_q[PW-1:0]] <= color_i;
            offs_q[wr_q[PW-1:0]]  <= offs_i;
        end
    end

endmodule

// File: rtl/ppu_write_arbiter.sv
// ppu_write_arbiter: round-robin merge of per-core pixel FIFOs onto one frame-buffer write port
module ppu_write_arbiter import gpu_pkg::*; #(
    parameter int COLOR_WIDTH   = DEF_COLOR_WIDTH,
    parameter int BUFFER_ADDR_W = DEF_BUFFER_ADDR_W,
    parameter int CORES_COUNT   = 10,
    parameter int SCREEN_X_SIZE = 800,
    parameter int SCREEN_Y_SIZE = 600,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [BUFFER_ADDR_W-1:0]                  fb_base,
    input  logic [CORES_COUNT-1:0][COLOR_WIDTH-1:0]   ppu_data,
    input  logic [CORES_COUNT-1:0][BUFFER_ADDR_W-1:0] ppu_address,
    input  logic [CORES_COUNT-1:0]                    ppu_valid,
    input  logic                                      frame_end,
    output logic [BUFFER_ADDR_W-1:0]                  mem_address,
    output logic [COLOR_WIDTH-1:0]                    mem_writedata,
    output logic                                      mem_write,
    input  logic                                      mem_waitrequest,
    output logic                                      idle,
    output logic                                      frame_done,
    output logic [CORES_COUNT-1:0]                    overflow,
    input  logic                                      clear_overflow
);

    localparam int GW           = CORES_COUNT > 1 ? $clog2(CORES_COUNT) : 1;
    localparam int REGION_WORDS = region_words(SCREEN_X_SIZE, SCREEN_Y_SIZE, CORES_COUNT);

    logic [CORES_COUNT-1:0]                    f_empty, f_full, push, pop;
    logic [CORES_COUNT-1:0][COLOR_WIDTH-1:0]   h_color;
    logic [CORES_COUNT-1:0][BUFFER_ADDR_W-1:0] h_offs;

    logic                     pend_q, pend_d, idle_q, idle_d, fd_q, fd_d, fp_q, fp_d;
    logic [BUFFER_ADDR_W-1:0] addr_q, addr_d;
    logic [COLOR_WIDTH-1:0]   data_q, data_d;
    logic [CORES_COUNT-1:0]   ovf_q, ovf_d;
    logic [GW-1:0]            rr_q, rr_d, gnt;
    logic                     found, load, take, drained;

    genvar i;
    generate
        for (i = 0; i < CORES_COUNT; i++) begin : g_fifo
            ppu_wr_fifo #(
                .DW    (COLOR_WIDTH),
                .AW    (BUFFER_ADDR_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .push_i  (push[i]),
                .pop_i   (pop[i]),
                .color_i (ppu_data[i]),
                .offs_i  (ppu_address[i]),
                .full_o  (f_full[i]),
                .empty_o (f_empty[i]),
                .color_o (h_color[i]),
                .offs_o  (h_offs[i])
            );
        end
    endgenerate

    // Round-robin search: cores at or above rr first, then wrap to the low cores
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < CORES_COUNT; k++) begin
            if (!found && !f_empty[k] && GW'(k) >= rr_q) begin
                found = 1'b1;
                gnt   = GW'(k);
            end
        end
        for (int k = 0; k < CORES_COUNT; k++) begin
            if (!found && !f_empty[k]) begin
                found = 1'b1;
                gnt   = GW'(k);
            end
        end
    end

    // Output register loads when empty or completing; pops and pushes follow from that
    always_comb begin
        load    = !pend_q || !mem_waitrequest;
        take    = load && found;
        pop     = take ? (CORES_COUNT'(1) << gnt) : '0;
        push    = ppu_valid & (~f_full | pop);
        pend_d  = load ? found : pend_q;
        addr_d  = take ? fb_base + BUFFER_ADDR_W'(int'(gnt) * REGION_WORDS) + h_offs[gnt] : addr_q;
        data_d  = take ? h_color[gnt] : data_q;
        rr_d    = take ? ((gnt == GW'(CORES_COUNT-1)) ? '0 : gnt + 1'b1) : rr_q;
        ovf_d   = (ovf_q & ~{CORES_COUNT{clear_overflow}}) | (ppu_valid & ~push);
        drained = (&f_empty) && (!pend_q || !mem_waitrequest);
        fd_d    = (fp_q || frame_end) && drained;
        fp_d    = !fd_d && (fp_q || frame_end);
        idle_d  = (&f_empty) && !pend_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            rr_q   <= '0;
            ovf_q  <= '0;
            idle_q <= 1'b1;
            fd_q   <= 1'b0;
            fp_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
            data_q <= data_d;
            rr_q   <= rr_d;
            ovf_q  <= ovf_d;
            idle_q <= idle_d;
            fd_q   <= fd_d;
            fp_q   <= fp_d;
        end
    end

    assign mem_write     = pend_q;
    assign mem_address   = addr_q;
    assign mem_writedata = data_q;
    assign idle          = idle_q;
    assign frame_done    = fd_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_ppu_write_arbiter.sv
// tb_ppu_write_arbiter: directed stimulus with a queue scoreboard and a write-port monitor
module tb_ppu_write_arbiter;
    import gpu_pkg::*;

    typedef struct packed {
        buf_addr_t a;
        color_t    d;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      fb_base = 32'h1000;
    logic [3:0][15:0] ppu_data = '0;
    logic [3:0][31:0] ppu_address = '0;
    logic [3:0]       ppu_valid = '0;
    logic             frame_end = 1'b0;
    logic [31:0]      mem_address;
    logic [15:0]      mem_writedata;
    logic             mem_write;
    logic             mem_waitrequest = 1'b0;
    logic             idle, frame_done;
    logic [3:0]       overflow;
    logic             clear_overflow = 1'b0;

    wr_t       exp_q[$];
    int        tests = 0, fails = 0;
    int        cyc = 0, comp_cnt = 0, last_cmp = 0, fd_cnt = 0, fd_cyc = 0;
    logic      held_v = 1'b0;
    buf_addr_t held_a;
    color_t    held_d;

    ppu_write_arbiter #(
        .COLOR_WIDTH   (16),
        .BUFFER_ADDR_W (32),
        .CORES_COUNT   (4),
        .SCREEN_X_SIZE (8),
        .SCREEN_Y_SIZE (8),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fb_base         (fb_base),
        .ppu_data        (ppu_data),
        .ppu_address     (ppu_address),
        .ppu_valid       (ppu_valid),
        .frame_end       (frame_end),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_write       (mem_write),
        .mem_waitrequest (mem_waitrequest),
        .idle            (idle),
        .frame_done      (frame_done),
        .overflow        (overflow),
        .clear_overflow  (clear_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(int c, logic [31:0] off, logic [15:0] d);
        ppu_valid[c]   = 1'b1;
        ppu_address[c] = off;
        ppu_data[c]    = d;
    endtask

    task automatic expect_wr(logic [31:0] a, logic [15:0] d);
        exp_q.push_back('{a: a, d: d});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(string nm);
        int n = 0;
        while (!(idle && exp_q.size() == 0) && n < 100) begin
            tick();
            n++;
        end
        check(nm, 32'(n < 100), 32'd1);
    endtask

    // Monitor: scoreboard compare on each completed write, hold-stability while stalled
    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (mem_write && held_v) begin
                check("hold_addr", mem_address, held_a);
                check("hold_data", 32'(mem_writedata), 32'(held_d));
            end
            held_v = mem_write && mem_waitrequest;
            held_a = mem_address;
            held_d = mem_writedata;
            if (mem_write && !mem_waitrequest) begin
                comp_cnt++;
                last_cmp = cyc;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %h data %h, none expected", mem_address, mem_writedata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", mem_address, e.a);
                    check("wr_data", 32'(mem_writedata), 32'(e.d));
                end
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, f0;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_writedata", 32'(mem_writedata), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overflow", 32'(overflow), 0);

        // single push, 2-cycle latency
        put(2, 3, 16'hABCD);
        expect_wr(32'h1023, 16'hABCD);
        tick();
        ppu_valid = '0;
        check("t1_write_early", 32'(mem_write), 0);
        tick();
        check("t1_write_lat", 32'(mem_write), 1);
        check("t1_addr", mem_address, 32'h1023);
        wait_drain("t1_drain");
        check("t1_idle", 32'(idle), 1);

        // round robin from rr=0, twice
        do_reset();
        put(0, 1, 16'h1111); put(1, 2, 16'h2222); put(2, 3, 16'h3333); put(3, 4, 16'h4444);
        expect_wr(32'h1001, 16'h1111); expect_wr(32'h1012, 16'h2222);
        expect_wr(32'h1023, 16'h3333); expect_wr(32'h1034, 16'h4444);
        tick();
        ppu_valid = '0;
        c0 = comp_cnt;
        repeat (5) tick();
        check("t2_back_to_back", 32'(comp_cnt - c0), 4);
        wait_drain("t2_drain1");
        put(0, 5, 16'h00A0); put(1, 5, 16'h00A1); put(2, 5, 16'h00A2); put(3, 5, 16'h00A3);
        expect_wr(32'h1005, 16'h00A0); expect_wr(32'h1015, 16'h00A1);
        expect_wr(32'h1025, 16'h00A2); expect_wr(32'h1035, 16'h00A3);
        tick();
        ppu_valid = '0;
        wait_drain("t2_drain2");

        // backpressure: 5 stalled cycles, completion on first free cycle
        mem_waitrequest = 1'b1;
        put(0, 0, 16'h0101); put(3, 9, 16'hBEEF);
        expect_wr(32'h1000, 16'h0101); expect_wr(32'h1039, 16'hBEEF);
        tick();
        ppu_valid = '0;
        repeat (5) tick();
        check("t3_pending", 32'(mem_write), 1);
        check("t3_addr_held", mem_address, 32'h1000);
        check("t3_idle_busy", 32'(idle), 0);
        c0 = comp_cnt;
        mem_waitrequest = 1'b0;
        tick();
        check("t3_complete", 32'(comp_cnt - c0), 1);
        wait_drain("t3_drain");

        // overflow: 6 pushes into register + 4-deep FIFO
        mem_waitrequest = 1'b1;
        for (int j = 0; j < 6; j++) begin
            put(1, 32'(j), 16'(16'h5000 + j));
            if (j < 5) expect_wr(32'(32'h1010 + j), 16'(16'h5000 + j));
            tick();
        end
        ppu_valid = '0;
        check("t4_overflow_set", 32'(overflow), 32'b0010);
        c0 = comp_cnt;
        mem_waitrequest = 1'b0;
        wait_drain("t4_drain");
        check("t4_write_count", 32'(comp_cnt - c0), 5);
        check("t4_overflow_sticky", 32'(overflow), 32'b0010);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("t4_overflow_clr", 32'(overflow), 0);

        // frame done: rr now 2, so order is core 2, 0, 1
        f0 = fd_cnt;
        mem_waitrequest = 1'b1;
        put(0, 7, 16'h00F0); put(1, 7, 16'h00F1); put(2, 7, 16'h00F2);
        expect_wr(32'h1027, 16'h00F2); expect_wr(32'h1007, 16'h00F0); expect_wr(32'h1017, 16'h00F1);
        tick();
        ppu_valid = '0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        repeat (2) tick();
        check("t5_no_early_done", 32'(fd_cnt - f0), 0);
        mem_waitrequest = 1'b0;
        wait_drain("t5_drain");
        repeat (3) tick();
        check("t5_one_pulse", 32'(fd_cnt - f0), 1);
        check("t5_pulse_cycle", 32'(fd_cyc), 32'(last_cmp + 1));

        // reset mid-frame with FIFOs partly full and a write pending
        mem_waitrequest = 1'b1;
        for (int j = 0; j < 6; j++) begin
            put(0, 32'(j), 16'(16'h6000 + j));
            put(3, 32'(j), 16'(16'h7000 + j));
            tick();
        end
        ppu_valid = '0;
        check("t6_pre_overflow", 32'(overflow), 32'b1001);
        check("t6_pre_pending", 32'(mem_write), 1);
        reset = 1'b1;
        tick();
        check("t6_rst_write", 32'(mem_write), 0);
        check("t6_rst_idle", 32'(idle), 1);
        check("t6_rst_overflow", 32'(overflow), 0);
        reset = 1'b0;
        mem_waitrequest = 1'b0;
        c0 = comp_cnt;
        repeat (10) tick();
        check("t6_no_stale", 32'(comp_cnt - c0), 0);
        check("t6_idle_after", 32'(idle), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ppu_write_arbiter.md
Name: ppu_write_arbiter

Overview:
- Merges the per-core pixel write streams from the parallel pixel cores into the single frame-buffer write port.
- Each core has its own small FIFO. A round-robin arbiter drains the FIFOs onto one memory master with a waitrequest handshake.
- Core-relative addresses are converted to absolute frame-buffer addresses.
- The block reports idle, frame completion and per-core overflow to the GPU sequencer.

Parameters:
- COLOR_WIDTH, 16, pixel data width
- BUFFER_ADDR_W, 32, address width of the ppu and memory interfaces
- CORES_COUNT, 10, number of ppu write streams
- SCREEN_X_SIZE, 800, pixels per line
- SCREEN_Y_SIZE, 600, lines per frame; must be divisible by CORES_COUNT
- FIFO_DEPTH, 4, entries per core FIFO; power of two, at least 2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fb_base  in  BUFFER_ADDR_W  frame-buffer base word address; stable for a whole frame
- ppu_data  in  [CORES_COUNT][COLOR_WIDTH]  per-core pixel colour
- ppu_address  in  [CORES_COUNT][BUFFER_ADDR_W]  per-core word offset within that core's region
- ppu_valid  in  [CORES_COUNT]  per-core write strobe
- frame_end  in  1  one-cycle pulse: the cores have finished the frame
- mem_address  out  BUFFER_ADDR_W  absolute write address
- mem_writedata  out  COLOR_WIDTH  write data
- mem_write  out  1  write request
- mem_waitrequest  in  1  slave stall
- idle  out  1  all FIFOs empty and no write outstanding
- frame_done  out  1  one-cycle pulse: frame fully written
- overflow  out  [CORES_COUNT]  sticky per-core drop flag
- clear_overflow  in  1  clears all overflow bits

Behaviour:
Constants:
- REGION_WORDS = SCREEN_X_SIZE*SCREEN_Y_SIZE/CORES_COUNT.
- Core i absolute address = fb_base + i*REGION_WORDS + ppu_address[i], computed modulo 2^BUFFER_ADDR_W. The addition is done at pop time.

Reset (synchronous):
- Applies on any cycle, including mid-frame.
- Flushes all FIFOs. Any pending write is discarded with no handshake completion.
- Output reset values: mem_write=0, mem_address=0, mem_writedata=0, idle=1, frame_done=0, overflow=0, rr pointer=0, frame-pending=0.

FIFO push:
- Core i pushes when ppu_valid[i]=1 and it is not full, or when it is full and popped in the same cycle.
- Otherwise the pixel is dropped and overflow[i] is set.
- clear_overflow clears all bits. A set and a clear in the same cycle leave the bit set.

Output register:
- States: EMPTY (mem_write=0) and PENDING (mem_write=1).
- A PENDING write completes on any cycle where mem_write=1 and mem_waitrequest=0.
- While mem_waitrequest=1, mem_address and mem_writedata are held stable.
- The register loads when EMPTY, or when completing this cycle. This gives back-to-back writes, one per cycle, with no bubble.
- On load, the winning FIFO head is popped and the register enters PENDING. If no FIFO is non-empty it enters EMPTY.

Arbitration:
- Round-robin: search starts at index rr, wrapping to 0 after CORES_COUNT-1.
- After granting core g, rr becomes (g+1) mod CORES_COUNT. rr is unchanged when nothing is granted.

Latency:
- A pixel pushed at edge k into an empty system has mem_write=1 after edge k+1, i.e. 2 cycles from ppu_valid to mem_write.
- Peak throughput: 1 write/cycle. The cores can produce up to CORES_COUNT/cycle, so sustained full-rate input overflows by design. The sequencer throttles the cores.

idle:
- Registered; equals (all FIFOs empty and output EMPTY) as of the previous edge.

frame_done:
- frame_end sets frame-pending.
- When frame-pending=1, all FIFOs are empty and the output is EMPTY (or completing with nothing left), frame_done pulses for exactly 1 cycle and frame-pending clears.
- If frame_end arrives while frame-pending is already set, it is merged (only one pulse).
- If frame_end coincides with the system already being drained, the pulse occurs on the next cycle.

Decomposition:
- Shared package gpu_pkg: typedefs color_t and buf_addr_t; function region_words().
- Sub-module ppu_wr_fifo: single-clock, synchronous active-high reset, FIFO_DEPTH entries of {color, offset}. Outputs full/empty/head. Instantiated CORES_COUNT times in a generate loop.
- Arbiter and output register are inline.

Test Plan:
1. Single push: CORES_COUNT=4, SCREEN 8x8, fb_base=0x1000, core 2 pushes offset 3, data 0xABCD, waitrequest=0. Expect mem_write high 2 cycles later with address 0x1000+2*16+3=0x1023, data 0xABCD. idle returns to 1 afterwards.
2. Round-robin: all 4 cores push one pixel in the same cycle. Expect write order cores 0,1,2,3 on consecutive cycles. A second simultaneous burst then also starts at core 0 (rr wrapped).
3. Backpressure: hold mem_waitrequest=1 for 5 cycles during a pending write. Expect address/data stable throughout, no FIFO pops, and completion on the first cycle with waitrequest=0.
4. Overflow: FIFO_DEPTH=4, waitrequest=1, core 1 pushes 6 pixels. Expect overflow[1]=1 and exactly 5 writes after release (1 in register + 4 in FIFO). clear_overflow then returns overflow to 0.
5. Frame done: pulse frame_end while 3 pixels are queued. Expect frame_done to pulse for 1 cycle, exactly the cycle after the last write completes. A second frame_end during pending produces no extra pulse.
6. Reset mid-frame: assert reset with FIFOs partially full and a write pending. Next cycle expect mem_write=0, idle=1, overflow=0, and no stale writes after deassertion.
